// File: rtl/regfile_sequencer.sv
// Bulk-access initiator for a 32-entry register file.
// Handles CLEAR (zero-fill), LOAD (stream in) and DUMP (stream out) over consecutive registers.
module regfile_sequencer #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned ADDR_BITS = 5
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [1:0]           Cmd,
   input  logic [ADDR_BITS-1:0] StartReg,
   input  logic [ADDR_BITS:0]   Count,
   input  logic                 CmdValid,
   output logic                 CmdReady,
   input  logic [WIDTH-1:0]     LoadData,
   input  logic                 LoadValid,
   output logic                 LoadReady,
   output logic [WIDTH-1:0]     DumpData,
   output logic [ADDR_BITS-1:0] DumpReg,
   output logic                 DumpValid,
   input  logic                 DumpReady,
   output logic                 Busy,
   output logic                 RegWrite,
   output logic [ADDR_BITS-1:0] WriteRegister,
   output logic [WIDTH-1:0]     WriteData,
   output logic [ADDR_BITS-1:0] ReadRegister1,
   input  logic [WIDTH-1:0]     ReadData1
);

   localparam int unsigned REM_W = ADDR_BITS + 1;

   // Encoding matches the Cmd field so an accepted command maps straight onto a state.
   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_CLEAR = 2'b01,
      S_LOAD  = 2'b10,
      S_DUMP  = 2'b11
   } state_t;

   state_t               state_q, state_d;
   logic [ADDR_BITS-1:0] ptr_q, ptr_d;
   logic [REM_W-1:0]     rem_q, rem_d;
   logic                 dump_valid_q, dump_valid_d;
   logic [WIDTH-1:0]     dump_data_q, dump_data_d;
   logic [ADDR_BITS-1:0] dump_reg_q, dump_reg_d;

   // State and datapath registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         rem_q        <= '0;
         dump_valid_q <= 1'b0;
         dump_data_q  <= '0;
         dump_reg_q   <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         rem_q        <= rem_d;
         dump_valid_q <= dump_valid_d;
         dump_data_q  <= dump_data_d;
         dump_reg_q   <= dump_reg_d;
      end
   end

   // Next-state and pointer/counter update.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      rem_d        = rem_q;
      dump_valid_d = dump_valid_q;
      dump_data_d  = dump_data_q;
      dump_reg_d   = dump_reg_q;
      unique case (state_q)
         S_IDLE: begin
            if (CmdValid) begin
               ptr_d = StartReg;
               rem_d = Count;
               if (Cmd != 2'b00 && Count != '0) begin
                  state_d = state_t'(Cmd);
               end
            end
         end
         S_CLEAR: begin
            ptr_d = ptr_q + ADDR_BITS'(1);
            rem_d = rem_q - REM_W'(1);
            if (rem_q == REM_W'(1)) state_d = S_IDLE;
         end
         S_LOAD: begin
            if (LoadValid) begin
               ptr_d = ptr_q + ADDR_BITS'(1);
               rem_d = rem_q - REM_W'(1);
               if (rem_q == REM_W'(1)) state_d = S_IDLE;
            end
         end
         S_DUMP: begin
            // Output buffer refills when empty or draining; leave once drained with nothing left.
            if (!dump_valid_q || DumpReady) begin
               if (rem_q != '0) begin
                  dump_valid_d = 1'b1;
                  dump_data_d  = (ptr_q == '0) ? '0 : ReadData1;
                  dump_reg_d   = ptr_q;
                  ptr_d        = ptr_q + ADDR_BITS'(1);
                  rem_d        = rem_q - REM_W'(1);
               end else begin
                  dump_valid_d = 1'b0;
                  state_d      = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode; a write is suppressed during reset so reset wins over a pending LOAD word.
   always_comb begin
      CmdReady  = (state_q == S_IDLE);
      LoadReady = (state_q == S_LOAD);
      Busy      = (state_q != S_IDLE);
      RegWrite  = 1'b0;
      WriteData = '0;
      unique case (state_q)
         S_CLEAR: RegWrite = !Reset;
         S_LOAD: begin
            RegWrite  = LoadValid && !Reset;
            WriteData = LoadData;
         end
         default: ;
      endcase
   end

   assign WriteRegister = ptr_q;
   assign ReadRegister1 = ptr_q;
   assign DumpData      = dump_data_q;
   assign DumpReg       = dump_reg_q;
   assign DumpValid     = dump_valid_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer: directed scenarios plus randomized commands,
// with a behavioural register-file image as the reference.
module tb_regfile_sequencer;

   localparam int unsigned NREG = 32;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [1:0]  Cmd;
   logic [4:0]  StartReg;
   logic [5:0]  Count;
   logic        CmdValid, CmdReady;
   logic [31:0] LoadData;
   logic        LoadValid, LoadReady;
   logic [31:0] DumpData;
   logic [4:0]  DumpReg;
   logic        DumpValid, DumpReady, Busy, RegWrite;
   logic [4:0]  WriteRegister, ReadRegister1;
   logic [31:0] WriteData, ReadData1;

   regfile_sequencer #(.WIDTH(32), .ADDR_BITS(5)) dut (
      .Clk(Clk), .Reset(Reset), .Cmd(Cmd), .StartReg(StartReg), .Count(Count),
      .CmdValid(CmdValid), .CmdReady(CmdReady), .LoadData(LoadData),
      .LoadValid(LoadValid), .LoadReady(LoadReady), .DumpData(DumpData),
      .DumpReg(DumpReg), .DumpValid(DumpValid), .DumpReady(DumpReady), .Busy(Busy),
      .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
      .ReadRegister1(ReadRegister1), .ReadData1(ReadData1)
   );

   always #5 Clk = ~Clk;

   // Register file attached to the sequencer (register 0 reads as zero, writes to it dropped).
   logic [31:0] rf [NREG];
   always @(posedge Clk) if (RegWrite && WriteRegister != 5'd0) rf[WriteRegister] <= WriteData;
   assign ReadData1 = (ReadRegister1 == 5'd0) ? 32'd0 : rf[ReadRegister1];

   typedef struct packed { logic [4:0] a; logic [31:0] d; } acc_t;
   acc_t        exp_wr_q[$];
   acc_t        exp_dump_q[$];
   logic [31:0] ref_mem [NREG];
   int          tests = 0, fails = 0;
   int          wr_seen = 0, dump_seen = 0;

   function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endfunction

   // Monitor: pops expected writes / dump words whenever the DUT presents one.
   acc_t        e;
   logic        stall_q = 1'b0;
   logic [31:0] held_d;
   logic [4:0]  held_r;
   always @(negedge Clk) begin
      if (RegWrite) begin
         wr_seen++;
         if (exp_wr_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_write: got reg %0d data %0h expected no write", WriteRegister, WriteData);
         end else begin
            e = exp_wr_q.pop_front();
            chk("write_reg", 64'(WriteRegister), 64'(e.a));
            chk("write_data", 64'(WriteData), 64'(e.d));
         end
      end
      if (DumpValid) begin
         if (stall_q) begin
            chk("dump_hold_data", 64'(DumpData), 64'(held_d));
            chk("dump_hold_reg", 64'(DumpReg), 64'(held_r));
         end
         if (DumpReady) begin
            dump_seen++;
            stall_q = 1'b0;
            if (exp_dump_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_dump: got reg %0d data %0h expected none", DumpReg, DumpData);
            end else begin
               e = exp_dump_q.pop_front();
               chk("dump_reg", 64'(DumpReg), 64'(e.a));
               chk("dump_data", 64'(DumpData), 64'(e.d));
            end
         end else begin
            stall_q = 1'b1;
            held_d  = DumpData;
            held_r  = DumpReg;
         end
      end else begin
         stall_q = 1'b0;
      end
   end

   task automatic step();
      @(posedge Clk); #1;
   endtask

   task automatic issue(input logic [1:0] cmd, input logic [4:0] start, input int cnt);
      int n = 0;
      while (!CmdReady && n < 300) begin step(); n++; end
      chk("cmd_ready_before_issue", 64'(CmdReady), 64'd1);
      Cmd = cmd; StartReg = start; Count = 6'(cnt); CmdValid = 1'b1;
      step();
      CmdValid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (Busy && n < 300) begin step(); n++; end
      chk(name, 64'(Busy), 64'd0);
   endtask

   task automatic run_clear(input logic [4:0] start, input int cnt, input bit poke_busy);
      int w0 = wr_seen;
      for (int i = 0; i < cnt; i++) begin
         exp_wr_q.push_back('{a: 5'(start + i), d: 32'd0});
         ref_mem[5'(start + i)] = 32'd0;
      end
      issue(2'b01, start, cnt);
      if (poke_busy && cnt > 1) begin
         // A command offered while busy must be dropped, not queued.
         Cmd = 2'b10; StartReg = 5'd20; Count = 6'd3; CmdValid = 1'b1;
         step();
         CmdValid = 1'b0;
      end
      wait_idle("clear_idle");
      chk("clear_write_count", 64'(wr_seen - w0), 64'(cnt));
      if (poke_busy) begin
         step(); step();
         chk("busy_cmd_ignored", 64'(Busy), 64'd0);
      end
   endtask

   task automatic run_load(input logic [4:0] start, input int cnt, input int gap_at, input bit rand_gaps);
      int          w0 = wr_seen;
      logic [31:0] d;
      logic [4:0]  a;
      issue(2'b10, start, cnt);
      for (int i = 0; i < cnt; i++) begin
         if (i == gap_at || (rand_gaps && $urandom_range(3) == 0)) begin
            LoadValid = 1'b0;
            step();
         end
         d = $urandom;
         a = 5'(start + i);
         exp_wr_q.push_back('{a: a, d: d});
         ref_mem[a] = d;
         LoadValid = 1'b1; LoadData = d;
         step();
      end
      LoadValid = 1'b0;
      wait_idle("load_idle");
      chk("load_write_count", 64'(wr_seen - w0), 64'(cnt));
   endtask

   task automatic run_dump(input logic [4:0] start, input int cnt, input int stall_at, input bit rand_stall);
      int         d0 = dump_seen;
      int         k = 0;
      logic [4:0] a;
      for (int i = 0; i < cnt; i++) begin
         a = 5'(start + i);
         exp_dump_q.push_back('{a: a, d: (a == 5'd0) ? 32'd0 : ref_mem[a]});
      end
      issue(2'b11, start, cnt);
      while (dump_seen - d0 < cnt && k < 500) begin
         DumpReady = rand_stall ? 1'($urandom_range(1)) : !(k == stall_at || k == stall_at + 1);
         step();
         k++;
      end
      DumpReady = 1'b0;
      chk("dump_word_count", 64'(dump_seen - d0), 64'(cnt));
      wait_idle("dump_idle");
   endtask

   initial begin
      logic [31:0] d;
      int          op, cnt;
      Reset = 1'b1; Cmd = 2'b00; StartReg = '0; Count = '0; CmdValid = 1'b0;
      LoadData = '0; LoadValid = 1'b0; DumpReady = 1'b0;
      repeat (2) step();
      chk("rst_cmd_ready", 64'(CmdReady), 64'd1);
      chk("rst_busy", 64'(Busy), 64'd0);
      chk("rst_regwrite", 64'(RegWrite), 64'd0);
      chk("rst_dump_valid", 64'(DumpValid), 64'd0);
      chk("rst_load_ready", 64'(LoadReady), 64'd0);
      chk("rst_dump_data", 64'(DumpData), 64'd0);
      chk("rst_ptr", 64'(WriteRegister), 64'd0);
      Reset = 1'b0;
      step();

      // Fill every register (Count=32 boundary) so the reference image is fully known.
      run_load(5'd0, 32, -1, 1'b0);
      run_clear(5'd3, 4, 1'b1);
      run_load(5'd30, 4, 1, 1'b0);
      run_dump(5'd30, 4, 2, 1'b0);

      // LOAD with Count=0 is a no-op.
      issue(2'b10, 5'd7, 0);
      chk("cnt0_busy", 64'(Busy), 64'd0);
      chk("cnt0_cmd_ready", 64'(CmdReady), 64'd1);
      step();
      chk("cnt0_regwrite", 64'(RegWrite), 64'd0);

      // Reset in the middle of a LOAD: only the first two words land.
      issue(2'b10, 5'd8, 5);
      for (int i = 0; i < 2; i++) begin
         d = $urandom;
         exp_wr_q.push_back('{a: 5'(8 + i), d: d});
         ref_mem[8 + i] = d;
         LoadValid = 1'b1; LoadData = d;
         step();
      end
      LoadValid = 1'b0; Reset = 1'b1;
      step();
      chk("midrst_busy", 64'(Busy), 64'd0);
      chk("midrst_cmd_ready", 64'(CmdReady), 64'd1);
      chk("midrst_load_ready", 64'(LoadReady), 64'd0);
      Reset = 1'b0;
      step();
      run_dump(5'd8, 5, -1, 1'b0);

      // Randomized command mix against the reference image.
      for (int it = 0; it < 30; it++) begin
         op  = int'($urandom_range(3));
         cnt = ($urandom_range(7) == 0) ? 32 : int'($urandom_range(10));
         d   = $urandom;
         unique case (op)
            0: begin
               issue(2'b00, 5'(d), cnt);
               chk("nop_busy", 64'(Busy), 64'd0);
            end
            1: run_clear(5'(d), cnt, 1'b0);
            2: run_load(5'(d), cnt, -1, 1'b1);
            default: run_dump(5'(d), cnt, -1, 1'b1);
         endcase
      end
      run_dump(5'd0, 32, -1, 1'b1);

      step(); step();
      chk("wr_queue_empty", 64'(exp_wr_q.size()), 64'd0);
      chk("dump_queue_empty", 64'(exp_dump_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
